coin_credit: RTL

//  Upstream front end for the vending statemachine. Synchronises and debounces the raw

---
 rtl/coin_credit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/coin_credit.sv
// Coin front end: sync + debounce coin_in, decode denomination, keep credit, vend debit, cancel refund.
// Credit/V update DEBOUNCE_CYC+3 edges after coin_in is first sampled high; cancel/vend act on the next edge.
module coin_credit #(
  parameter int PRICE        = 50,
  parameter int CREDIT_W     = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  input  logic                vend,
  output logic                V,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amt,
  output logic                coin_reject
);

  localparam int                  CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);

  typedef enum logic [1:0] {IDLE, COLLECT, READY, REFUND} state_t;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                deb_q, deb_d;
  logic                deb_prev_q, deb_prev_d;
  logic                coin_evt_q, coin_evt_d;
  logic [CREDIT_W-1:0] coin_amt_q, coin_amt_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
  logic                coin_reject_q, coin_reject_d;
  state_t              state_q, state_d;

  logic                cancel_ok;
  logic                vend_ok;
  logic                add_ok;
  logic [CREDIT_W-1:0] base_cr;
  logic [CREDIT_W:0]   sum_w;
  logic [CREDIT_W-1:0] eff_cr;

  always_comb begin
    sync1_d    = coin_in;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Rising edge of the debounced level; denomination captured alongside it.
    coin_evt_d = deb_q & ~deb_prev_q;
    case (coin_val)
      2'd0:    coin_amt_d = CREDIT_W'(5);
      2'd1:    coin_amt_d = CREDIT_W'(10);
      2'd2:    coin_amt_d = CREDIT_W'(20);
      default: coin_amt_d = CREDIT_W'(50);
    endcase
  end

  always_comb begin
    cancel_ok     = cancel && ((state_q == COLLECT) || (state_q == READY));
    vend_ok       = vend && (state_q == READY) && !cancel_ok;
    base_cr       = vend_ok ? (credit_q - PRICE_C) : credit_q;
    sum_w         = {1'b0, base_cr} + {1'b0, coin_amt_q};
    add_ok        = coin_evt_q && !sum_w[CREDIT_W];
    coin_reject_d = coin_evt_q && sum_w[CREDIT_W];
    eff_cr        = add_ok ? sum_w[CREDIT_W-1:0] : base_cr;
    refund_amt_d  = refund_amt_q;
    credit_d      = eff_cr;
    state_d       = IDLE;
    if (cancel_ok) begin
      refund_amt_d = eff_cr;
      credit_d     = '0;
      state_d      = REFUND;
    end else if (eff_cr == '0) begin
      state_d = IDLE;
    end else if (eff_cr >= PRICE_C) begin
      state_d = READY;
    end else begin
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      deb_q         <= 1'b0;
      deb_prev_q    <= 1'b0;
      coin_evt_q    <= 1'b0;
      coin_amt_q    <= '0;
      credit_q      <= '0;
      refund_amt_q  <= '0;
      coin_reject_q <= 1'b0;
      state_q       <= IDLE;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cnt_q         <= cnt_d;
      deb_q         <= deb_d;
      deb_prev_q    <= deb_prev_d;
      coin_evt_q    <= coin_evt_d;
      coin_amt_q    <= coin_amt_d;
      credit_q      <= credit_d;
      refund_amt_q  <= refund_amt_d;
      coin_reject_q <= coin_reject_d;
      state_q       <= state_d;
    end
  end

  assign V            = (state_q == READY);
  assign credit       = credit_q;
  assign refund_valid = (state_q == REFUND);
  assign refund_amt   = refund_amt_q;
  assign coin_reject  = coin_reject_q;

endmodule
